// File: rtl/mem_responder.sv
// mem_responder: word-addressed synchronous RAM behind the proc_req/mem_rdy/valid
// handshake. One request is outstanding at a time, and each request waits a
// programmable LATENCY. Writes use byte enables. The same block serves as the
// instruction memory and as the data memory.
//
// Optional feature (build macro MEMRESP_ERR_EN):
//   defined   - adds an 'err' output. An access at or above DEPTH*4 bytes is
//               suppressed. It still gets a valid, which comes with err=1.
//   undefined - no 'err' port. Addresses wrap modulo DEPTH*4.
//
// Timing for a request accepted at edge k:
//   - mem_rdy is low for LATENCY+1 cycles.
//   - valid is high for one cycle, after edge k+1+LATENCY.
//   - The next request can be accepted in the cycle that valid is high.
module mem_responder #(
  parameter int nbits   = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             proc_req,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [nbits-1:0] addr,
  input  logic [nbits-1:0] wdata,
  output logic             mem_rdy,
  output logic             valid,
  output logic [nbits-1:0] rdata
`ifdef MEMRESP_ERR_EN
  ,
  output logic             err
`endif
);

  localparam int         AW  = $clog2(DEPTH);
  localparam logic [3:0] LAT = 4'(LATENCY);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_r;
  logic [3:0]       cnt_r;
  logic             we_r;
  logic [3:0]       be_r;
  logic [AW-1:0]    idx_r;
  logic [nbits-1:0] wdata_r;
  logic             mem_rdy_r;
  logic             valid_r;
  logic [nbits-1:0] rdata_r;
  logic             access_ok_s;
  logic             mem_we_s;
  logic             unused_s;

  logic [nbits-1:0] mem_r [DEPTH];

`ifdef MEMRESP_ERR_EN
  localparam logic [nbits-1:0] LIMIT = nbits'(DEPTH * 4);
  logic oor_r;
  logic err_r;
  assign err      = err_r;
  assign unused_s = ^addr[1:0];
`else
  assign unused_s = ^{addr[nbits-1:AW+2], addr[1:0]};
`endif

  assign mem_rdy = mem_rdy_r;
  assign valid   = valid_r;
  assign rdata   = rdata_r;

  // Byte-lane merge: enabled lanes take the new data, the rest keep the old word.
  function automatic logic [nbits-1:0] merge_bytes(
    input logic [nbits-1:0] old_word,
    input logic [nbits-1:0] new_word,
    input logic [3:0]       lanes
  );
    logic [nbits-1:0] result;
    result = old_word;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) begin
        result[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        result[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return result;
  endfunction

  // Decides whether the captured access may touch the RAM, and whether this edge writes.
  always_comb begin
    access_ok_s = 1'b1;
`ifdef MEMRESP_ERR_EN
    access_ok_s = ~oor_r;
`endif
    mem_we_s = 1'b0;
    if ((state_r == RESP) && we_r && access_ok_s) begin
      mem_we_s = 1'b1;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // RAM write port. The whole merged word is written in one edge, so a reset
  // can never leave a partial write. Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[idx_r] <= merge_bytes(mem_r[idx_r], wdata_r, be_r);
    end
  end

  // Handshake FSM: captures the request, counts the latency and raises the registered response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      cnt_r     <= 4'd0;
      we_r      <= 1'b0;
      be_r      <= 4'd0;
      idx_r     <= '0;
      wdata_r   <= '0;
      mem_rdy_r <= 1'b1;
      valid_r   <= 1'b0;
      rdata_r   <= '0;
`ifdef MEMRESP_ERR_EN
      oor_r     <= 1'b0;
      err_r     <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          valid_r <= 1'b0;
`ifdef MEMRESP_ERR_EN
          err_r   <= 1'b0;
`endif
          if (proc_req) begin
            we_r      <= we;
            be_r      <= be;
            idx_r     <= addr[AW+1:2];
            wdata_r   <= wdata;
`ifdef MEMRESP_ERR_EN
            oor_r     <= (addr >= LIMIT);
`endif
            mem_rdy_r <= 1'b0;
            cnt_r     <= LAT;
            state_r   <= (LAT == 4'd0) ? RESP : WAIT;
          end else begin
            mem_rdy_r <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt_r <= 4'd1) begin
            cnt_r   <= 4'd0;
            state_r <= RESP;
          end else begin
            cnt_r   <= cnt_r - 4'd1;
          end
        end
        RESP: begin
          valid_r   <= 1'b1;
          mem_rdy_r <= 1'b1;
          state_r   <= IDLE;
`ifdef MEMRESP_ERR_EN
          err_r     <= oor_r;
`endif
          if (!we_r) begin
            rdata_r <= access_ok_s ? mem_r[idx_r] : '0;
          end else begin
            rdata_r <= rdata_r;
          end
        end
        default: begin
          state_r   <= IDLE;
          mem_rdy_r <= 1'b1;
          valid_r   <= 1'b0;
          cnt_r     <= 4'd0;
        end
      endcase
    end
  end

endmodule
